addsub_serial_ctrl: RTL and testbench
=====================================

# addsub_serial_ctrl

Multi-cycle controller that performs W-bit add/subtract (W = 4·NIBBLES) by stepping operands through a 4-bit add/sub nibble datapath, least-significant nibble first, one nibble per clock. It is the stage directly upstream of the nibble adder-subtractor. It latches wide operands on a start handshake, feeds each nibble and the mode bit into the nibble datapath, and collects the per-nibble sums into a registered W-bit result with carry and optional flags. The nibble datapath is four `fulladder` cells with an explicit carry-in driven from this block's carry register, so nibbles chain correctly.

## Interface
- NIBBLES, 4, number of 4-bit nibbles; W = 4·NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE
- a  input  W  operand A, sampled on accepting edge
- b  input  W  operand B, sampled on accepting edge
- m  input  1  mode, 0 = A+B, 1 = A−B; sampled on accepting edge
- busy  output  1  high while state is RUN
- done  output  1  one-cycle completion pulse
- s  output  W  result register
- cout  output  1  carry out of MSB; in subtract, 1 = no borrow (A ≥ B unsigned)
- ovf  output  1  signed two's-complement overflow (see Configuration)
- zero  output  1  s == 0 (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b and m into internal regs, sets the carry register to m, clears the nibble counter, and goes to RUN.
  - RUN: each edge processes nibble k = counter.
    - Nibble inputs are a[4k+3:4k] and b[4k+3:4k] XOR {4{m}}, with carry-in from the carry register.
    - The 4-bit sum is written to the internal accumulator nibble k, the carry register takes the nibble carry-out, and the counter increments.
    - On the edge processing nibble NIBBLES−1: copy the accumulator (with the final nibble) to s, set cout to the final carry, update flags, set done=1, and go to DONE.
  - DONE: next edge returns to IDLE unconditionally and clears done.
- start is ignored in RUN and DONE. There is no queuing. Operand inputs may change freely after the accepting edge.
- s, cout, ovf and zero change only on the completion edge and hold until the next completion or reset. Partial results are never visible on s.
- Arithmetic is modulo 2^W. ovf = (carry into bit W−1) XOR (carry out of bit W−1).
- Counter width is ceil(log2(NIBBLES)), minimum 1. With NIBBLES=1, RUN lasts exactly one edge.
- Reset (rst_n=0 at an edge) applies in any state:
  - state goes to IDLE, and s, cout, ovf, zero, busy and done all go to 0;
  - internal operand, accumulator, carry and counter registers clear;
  - an in-flight operation is abandoned with no done pulse;
  - start at a reset edge is ignored.

## Timing
- Reset values: s=0, cout=0, ovf=0, zero=0, busy=0, done=0.
- Accepting edge E0: busy=1 from E0 until edge E0+NIBBLES.
- Result edge E0+NIBBLES: s, cout and flags become valid, done=1, busy=0.
- Edge E0+NIBBLES+1: done=0. This edge is in DONE, so start here is ignored.
- Earliest next acceptance is edge E0+NIBBLES+2.
- Throughput is one operation per NIBBLES+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- ADDSUB_FLAGS_EN defined: ovf and zero are computed and registered at the completion edge as described above.
- ADDSUB_FLAGS_EN undefined: ovf and zero ports still exist but are tied to constant 0. The MSB carry-in tap and the zero-detect logic are not built. s, cout, busy and done behaviour is identical either way.

## Test plan
All scenarios use NIBBLES=4 with ADDSUB_FLAGS_EN defined unless noted.
- Add: a=0x1234, b=0x1111, m=0, start at E0 → busy high for 4 cycles; at E0+4 s=0x2345, cout=0, ovf=0, zero=0, done=1 for exactly one cycle.
- Wrap: a=0xFFFF, b=0x0001, m=0 → s=0x0000, cout=1, zero=1, ovf=0. Second case: a=0x7FFF, b=0x0001, m=0 → s=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, m=1 → s=0xFFFE, cout=0 (borrow), ovf=0. Second case: a=0x8000, b=0x0001, m=1 → s=0x7FFF, cout=1, ovf=1.
- Handshake: hold start=1 continuously with a=0x0001, b=0x0001, m=0 → done pulses at E0+4, E0+10, E0+16. Operands changed during RUN do not affect s (stays 0x0002).
- Reset mid-op: start a=0x1234, b=0x1111, m=0, then rst_n=0 at E0+2 → all outputs 0 and no done pulse. Restart with a=0x00FF, b=0x0001, m=0 → s=0x0100 at the new E0+4.
- Flags disabled (ADDSUB_FLAGS_EN undefined): repeat the wrap and subtract cases → s and cout unchanged from above; ovf=0 and zero=0 throughout.

Source files
------------

// File: rtl/addsub_serial_ctrl.sv
// Serial W-bit add/sub controller: steps operands one nibble per clock through a 4-bit fulladder chain, LSB nibble first.
// Latency: result, flags and done appear NIBBLES edges after the accepting edge; one op per NIBBLES+2 cycles.
// Backpressure: start is honoured only in IDLE and is ignored in RUN/DONE, with no queuing. ADDSUB_FLAGS_EN enables the ovf/zero flags.
module addsub_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 m,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          m_r;
  logic          carry_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    sum;
  logic [4:0]    c;
  logic [W-1:0]  acc_full;
  logic          fin;

  // Select the current nibble; subtract is A + ~B + 1 with the +1 entering via carry_r.
  always_comb begin
    a_nib = a_r[{cnt, 2'b00} +: 4];
    b_nib = b_r[{cnt, 2'b00} +: 4] ^ {4{m_r}};
  end

  // Nibble datapath: four ripple-chained fulladder cells seeded from the carry register.
  assign c[0] = carry_r;
  for (genvar i = 0; i < 4; i++) begin : g_fulladder
    assign sum[i]   = a_nib[i] ^ b_nib[i] ^ c[i];
    assign c[i+1]   = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
  end

  // Accumulator with the nibble being processed this cycle merged in.
  always_comb begin
    acc_full = acc;
    acc_full[{cnt, 2'b00} +: 4] = sum;
  end

  assign fin = (state == RUN) && (cnt == LAST);

  // Control FSM, operand capture, nibble stepping and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      m_r     <= 1'b0;
      carry_r <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            m_r     <= m;
            carry_r <= m;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_full;
          carry_r <= c[4];
          cnt     <= cnt + 1'b1;
          if (fin) begin
            s     <= acc_full;
            cout  <= c[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_FLAGS_EN
  // Flags update only on the completion edge; ovf compares carry into and out of the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (fin) begin
      ovf  <= c[3] ^ c[4];
      zero <= (acc_full == '0);
    end
  end
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Self-checking bench for addsub_serial_ctrl with NIBBLES=4.
// Expected results come from a wide-arithmetic model pushed to a scoreboard queue.
// Flag expectations follow ADDSUB_FLAGS_EN as seen by this compile.
module tb_addsub_serial_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         m     = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] s;

  addsub_serial_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .m(m),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic mm);
    logic [W-1:0] bo;
    logic [W:0]   t;
    exp_t         e;
    bo = mm ? ~bb : bb;
    t  = {1'b0, aa} + {1'b0, bo} + (W+1)'(mm);
    e.s    = t[W-1:0];
    e.cout = t[W];
`ifdef ADDSUB_FLAGS_EN
    e.ovf  = (aa[W-1] == bo[W-1]) && (e.s[W-1] != aa[W-1]);
    e.zero = (e.s == '0);
`else
    e.ovf  = 1'b0;
    e.zero = 1'b0;
`endif
    return e;
  endfunction

  // Present one request; returns 1 ns after the accepting edge with start dropped.
  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic mm);
    @(negedge clk);
    a = aa; b = bb; m = mm; start = 1'b1;
    q.push_back(model(aa, bb, mm));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); m = 1'($urandom);
  endtask

  // Wait (bounded) for done; reports edges after E0 and cycles busy was seen high.
  task automatic wait_done(output int edges, output int busy_cnt, output bit to);
    edges = 0; to = 1'b0;
    busy_cnt = busy ? 1 : 0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (busy) busy_cnt++;
      if (edges > 40) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h1111; m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, cout, ovf, zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got s=%h cout=%b ovf=%b zero=%b busy=%b done=%b want all 0", s, cout, ovf, zero, busy, done);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored got busy=%b want 0", busy);
    end
  endtask

  task automatic test_add();
    int edges, bc; bit to; exp_t e;
    launch(16'h1234, 16'h1111, 1'b0);
    wait_done(edges, bc, to);
    checks++;
    if (to || edges != N) begin
      failures++;
      $display("FAIL add_latency got %0d edges (timeout=%0b) want %0d", edges, to, N);
    end
    checks++;
    if (bc != N || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_busy got busy cycles=%0d busy_at_done=%b want %0d and 0", bc, busy, N);
    end
    e = q.pop_front();
    checks++;
    if ({s, cout, ovf, zero} !== {e.s, e.cout, e.ovf, e.zero}) begin
      failures++;
      $display("FAIL add_result got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b", s, cout, ovf, zero, e.s, e.cout, e.ovf, e.zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || s !== e.s) begin
      failures++;
      $display("FAIL add_done_pulse got done=%b s=%h want done=0 s=%h", done, s, e.s);
    end
  endtask

  // Table-driven arithmetic corner cases: wrap, signed overflow, borrow.
  task automatic test_corners();
    logic [W-1:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [W-1:0] tb[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic         tm[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int edges, bc; bit to; exp_t e;
      launch(ta[i], tb[i], tm[i]);
      wait_done(edges, bc, to);
      e = q.pop_front();
      checks++;
      if (to || {s, cout, ovf, zero} !== {e.s, e.cout, e.ovf, e.zero}) begin
        failures++;
        $display("FAIL corner_%0d got s=%h c=%b v=%b z=%b to=%0b want s=%h c=%b v=%b z=%b", i, s, cout, ovf, zero, to, e.s, e.cout, e.ovf, e.zero);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; m = 1'b0; start = 1'b1;
    repeat (3) q.push_back(model(16'h0001, 16'h0001, 1'b0));
    for (int n = 0; n <= 17; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (n != 4 + 6 * ndone || s !== e.s || cout !== e.cout) begin
          failures++;
          $display("FAIL b2b_done_%0d got edge=%0d s=%h c=%b want edge=%0d s=%h c=%b", ndone, n, s, cout, 4 + 6 * ndone, e.s, e.cout);
        end
        ndone++;
      end
      if ((n % 6) < 3) begin
        a = 16'($urandom); b = 16'($urandom); m = 1'($urandom);
      end else begin
        a = 16'h0001; b = 16'h0001; m = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL b2b_count got %0d done pulses want 3", ndone);
    end
    while (q.size() > 0) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int edges, bc; bit to; exp_t e; bit saw_done;
    launch(16'h1234, 16'h1111, 1'b0);
    void'(q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({s, cout, ovf, zero, busy, done} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got s=%h cout=%b ovf=%b zero=%b busy=%b done=%b want all 0", s, cout, ovf, zero, busy, done);
    end
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midreset_abandon got done/busy activity after reset want none");
    end
    launch(16'h00FF, 16'h0001, 1'b0);
    wait_done(edges, bc, to);
    e = q.pop_front();
    checks++;
    if (to || edges != N || {s, cout, ovf, zero} !== {e.s, e.cout, e.ovf, e.zero}) begin
      failures++;
      $display("FAIL midreset_restart got s=%h c=%b edges=%0d want s=%h c=%b edges=%0d", s, cout, edges, e.s, e.cout, N);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_corners();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
